// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with delayed sync/blank; optional VGA_FRAME_COUNT_EN frame counter
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HC_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_L    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Reject configurations the delay lines or 10-bit counters cannot represent.
  generate
    if (BLANK_DELAY < 0 || BLANK_DELAY > 4) begin : g_bad_blank_delay
      $error("vga_timing_gen: BLANK_DELAY must be in 0..4");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_sync_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H/V totals must fit 10-bit counters");
    end
  endgenerate

  logic [9:0] hc;
  logic [9:0] vc;
  logic       vis;
  logic       hs_raw;
  logic       vs_raw;

  // Raster counters: hc every clock, vc only on the clock where hc wraps.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HC_LAST) begin
      hc <= '0;
      if (vc == VC_LAST) begin
        vc <= '0;
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Undelayed decodes of the current raster position.
  always_comb begin
    vis        = (hc < H_VIS_L) && (vc < V_VIS_L);
    hs_raw     = !((hc >= HS_START) && (hc < HS_END));
    vs_raw     = !((vc >= VS_START) && (vc < VS_END));
    frame_tick = (hc == 10'd0) && (vc == V_VIS_L);
  end

  // blank delay line; stages clear to "not visible" so nothing shows until live data arrives.
  generate
    if (BLANK_DELAY == 0) begin : g_blank_comb
      assign blank = vis;
    end else begin : g_blank_pipe
      logic [BLANK_DELAY-1:0] blank_sr;

      // Shift vis through BLANK_DELAY plain registers.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          blank_sr <= '0;
        end else begin
          blank_sr[0] <= vis;
          for (int i = 1; i < BLANK_DELAY; i++) begin
            blank_sr[i] <= blank_sr[i-1];
          end
        end
      end

      assign blank = blank_sr[BLANK_DELAY-1];
    end
  endgenerate

  // hs/vs delay lines; stages clear to the inactive (high) sync level.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_comb
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_sync_pipe
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;

      // Shift both sync decodes through SYNC_DELAY plain registers.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_sr <= '1;
          vs_sr <= '1;
        end else begin
          hs_sr[0] <= hs_raw;
          vs_sr[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
          end
        end
      end

      assign hs = hs_sr[SYNC_DELAY-1];
      assign vs = vs_sr[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  // Count vblank starts; the new value is visible the clock after frame_tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int D_HV = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VV = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
  localparam int D_HT = 800, D_VT = 525;
  localparam int S_HV = 20, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int S_VV = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_HT = 32, S_VT = 19, S_FT = 608;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] d_x, d_y, f_x, f_y, p_x, p_y;
  logic d_bl, d_hs, d_vs, d_ft, f_bl, f_hs, f_vs, f_ft, p_bl, p_hs, p_vs, p_ft;
  logic [15:0] d_fc, f_fc, p_fc;
  logic [39:0] obs_d, obs_f, obs_p;

  int total = 0;
  int bad = 0;
  int k = 0;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen u_dflt (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_bl),
    .hs(d_hs), .vs(d_vs), .frame_tick(d_ft), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .BLANK_DELAY(0), .SYNC_DELAY(0)
  ) u_fast (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(f_x), .DrawY(f_y), .blank(f_bl),
    .hs(f_hs), .vs(f_vs), .frame_tick(f_ft), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .BLANK_DELAY(3), .SYNC_DELAY(4)
  ) u_deep (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(p_x), .DrawY(p_y), .blank(p_bl),
    .hs(p_hs), .vs(p_vs), .frame_tick(p_ft), .frame_count(p_fc)
  );

  assign obs_d = {d_x, d_y, d_bl, d_hs, d_vs, d_ft, d_fc};
  assign obs_f = {f_x, f_y, f_bl, f_hs, f_vs, f_ft, f_fc};
  assign obs_p = {p_x, p_y, p_bl, p_hs, p_vs, p_ft, p_fc};

  // Frames completed: one tick per frame at (0, vv), counter shows it one clock later.
  function automatic logic [15:0] e_fc(int kk, int ht, int vt, int vv);
`ifdef VGA_FRAME_COUNT_EN
    if (kk - 1 < vv * ht) return 16'h0000;
    return 16'(((kk - 1 - vv * ht) / (ht * vt)) + 1);
`else
    if (kk < 0 || ht < 0 || vt < 0 || vv < 0) return 16'h0000;
    return 16'h0000;
`endif
  endfunction

  // Expected outputs kk clocks after reset release, from raster position arithmetic.
  function automatic logic [39:0] e_vec(int kk, int ht, int vt, int hv, int hfp, int hsy,
                                        int vv, int vfp, int vsy, int bd, int sd);
    int x, y, xb, yb, xs, ys;
    logic bl, h, v, t;
    x = kk % ht;
    y = (kk / ht) % vt;
    bl = 1'b0;
    h = 1'b1;
    v = 1'b1;
    if (kk >= bd) begin
      xb = (kk - bd) % ht;
      yb = ((kk - bd) / ht) % vt;
      bl = (xb < hv) && (yb < vv);
    end
    if (kk >= sd) begin
      xs = (kk - sd) % ht;
      ys = ((kk - sd) / ht) % vt;
      h = !((xs >= hv + hfp) && (xs < hv + hfp + hsy));
      v = !((ys >= vv + vfp) && (ys < vv + vfp + vsy));
    end
    t = (x == 0) && (y == vv);
    return {10'(x), 10'(y), bl, h, v, t, e_fc(kk, ht, vt, vv)};
  endfunction

  function automatic logic [39:0] e_d(int kk);
    return e_vec(kk, D_HT, D_VT, D_HV, D_HFP, D_HS, D_VV, D_VFP, D_VS, 1, 2);
  endfunction

  function automatic logic [39:0] e_f(int kk);
    return e_vec(kk, S_HT, S_VT, S_HV, S_HFP, S_HS, S_VV, S_VFP, S_VS, 0, 0);
  endfunction

  function automatic logic [39:0] e_p(int kk);
    return e_vec(kk, S_HT, S_VT, S_HV, S_HFP, S_HS, S_VV, S_VFP, S_VS, 3, 4);
  endfunction

  task automatic do_release();
    @(negedge vga_clk);
    reset_n = 1'b1;
    k = 0;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    do_release();
  endtask

  task automatic step();
    @(posedge vga_clk);
    k++;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    k = 0;
    repeat (3) begin
      @(posedge vga_clk);
      #1;
      total++; if (obs_d !== e_d(0)) begin bad++; $display("FAIL reset_dflt got=%h exp=%h", obs_d, e_d(0)); end
      total++; if (obs_f !== e_f(0)) begin bad++; $display("FAIL reset_fast got=%h exp=%h", obs_f, e_f(0)); end
      total++; if (obs_p !== e_p(0)) begin bad++; $display("FAIL reset_deep got=%h exp=%h", obs_p, e_p(0)); end
    end
  endtask

  task automatic test_default_line();
    int n, hs_first, hs_cnt, bl_cnt, bl_first, y_at_800;
    n = 1700 + int'($urandom_range(0, 150));
    hs_first = -1; hs_cnt = 0; bl_cnt = 0; bl_first = -1; y_at_800 = -1;
    do_reset();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_d !== e_d(k)) begin bad++; $display("FAIL line_dflt k=%0d got=%h exp=%h", k, obs_d, e_d(k)); end
      if (k < D_HT) begin
        if (!d_hs) begin
          if (hs_first < 0) hs_first = int'(d_x);
          hs_cnt++;
        end
        if (d_bl) begin
          if (bl_first < 0) bl_first = k;
          bl_cnt++;
        end
      end
      if (k == D_HT) y_at_800 = int'(d_y);
      step();
    end
    total++; if (hs_first != 658) begin bad++; $display("FAIL hs_first_x got=%0d exp=658", hs_first); end
    total++; if (hs_cnt != 96) begin bad++; $display("FAIL hs_low_len got=%0d exp=96", hs_cnt); end
    total++; if (bl_first != 1) begin bad++; $display("FAIL blank_first got=%0d exp=1", bl_first); end
    total++; if (bl_cnt != 640) begin bad++; $display("FAIL blank_len got=%0d exp=640", bl_cnt); end
    total++; if (y_at_800 != 1) begin bad++; $display("FAIL drawy_wrap got=%0d exp=1", y_at_800); end
  endtask

  task automatic test_small_frames();
    int ticks, vs_low_f, vs_low_p, wraps, vs_first_x, vs_first_y, px, py;
    ticks = 0; vs_low_f = 0; vs_low_p = 0; wraps = 0;
    vs_first_x = -1; vs_first_y = -1; px = -1; py = -1;
    do_reset();
    for (int i = 0; i < 3 * S_FT; i++) begin
      total++;
      if (obs_f !== e_f(k)) begin bad++; $display("FAIL frame_fast k=%0d got=%h exp=%h", k, obs_f, e_f(k)); end
      total++;
      if (obs_p !== e_p(k)) begin bad++; $display("FAIL frame_deep k=%0d got=%h exp=%h", k, obs_p, e_p(k)); end
      if (f_ft) ticks++;
      if (!f_vs) vs_low_f++;
      if (!p_vs) begin
        vs_low_p++;
        if (vs_first_x < 0) begin vs_first_x = int'(p_x); vs_first_y = int'(p_y); end
      end
      if (px == S_HT - 1 && py == S_VT - 1) begin
        wraps++;
        total++;
        if (f_x !== 10'd0 || f_y !== 10'd0) begin bad++; $display("FAIL corner_wrap got=(%0d,%0d) exp=(0,0)", f_x, f_y); end
      end
      px = int'(f_x); py = int'(f_y);
      step();
    end
    total++; if (ticks != 3) begin bad++; $display("FAIL tick_count got=%0d exp=3", ticks); end
    total++; if (vs_low_f != 3 * S_VS * S_HT) begin bad++; $display("FAIL vs_len_fast got=%0d exp=%0d", vs_low_f, 3 * S_VS * S_HT); end
    total++; if (vs_low_p != 3 * S_VS * S_HT) begin bad++; $display("FAIL vs_len_deep got=%0d exp=%0d", vs_low_p, 3 * S_VS * S_HT); end
    total++; if (vs_first_x != 4 || vs_first_y != S_VV + S_VFP) begin bad++; $display("FAIL vs_start_deep got=(%0d,%0d) exp=(4,%0d)", vs_first_x, vs_first_y, S_VV + S_VFP); end
    total++; if (wraps != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", wraps); end
  endtask

  task automatic test_async_reset();
    int r, n;
    for (int it = 0; it < 2; it++) begin
      r = int'($urandom_range(100, 1500));
      do_reset();
      for (int i = 0; i < r; i++) step();
      total++;
      if (obs_d !== e_d(k)) begin bad++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs_d, e_d(k)); end
      #9;
      reset_n = 1'b0;
      #1;
      k = 0;
      total++; if (obs_d !== e_d(0)) begin bad++; $display("FAIL async_dflt got=%h exp=%h", obs_d, e_d(0)); end
      total++; if (obs_f !== e_f(0)) begin bad++; $display("FAIL async_fast got=%h exp=%h", obs_f, e_f(0)); end
      total++; if (obs_p !== e_p(0)) begin bad++; $display("FAIL async_deep got=%h exp=%h", obs_p, e_p(0)); end
      repeat (2) @(posedge vga_clk);
      #1;
      total++; if (obs_d !== e_d(0)) begin bad++; $display("FAIL held_reset got=%h exp=%h", obs_d, e_d(0)); end
      do_release();
      n = int'($urandom_range(40, 120));
      for (int i = 0; i < n; i++) begin
        total++;
        if (obs_d !== e_d(k)) begin bad++; $display("FAIL restart_dflt k=%0d got=%h exp=%h", k, obs_d, e_d(k)); end
        total++;
        if (obs_p !== e_p(k)) begin bad++; $display("FAIL restart_deep k=%0d got=%h exp=%h", k, obs_p, e_p(k)); end
        step();
      end
    end
  endtask

  task automatic test_frame_count();
    int n;
    n = 5 * S_FT + int'($urandom_range(0, 600));
    do_reset();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs_f !== e_f(k)) begin bad++; $display("FAIL fc_run k=%0d got=%h exp=%h", k, obs_f, e_f(k)); end
      step();
    end
    total++;
    if (f_fc !== e_fc(k, S_HT, S_VT, S_VV)) begin bad++; $display("FAIL frame_count got=%0d exp=%0d", f_fc, e_fc(k, S_HT, S_VT, S_VV)); end
    total++;
    if (d_fc !== 16'h0000) begin bad++; $display("FAIL fc_dflt got=%0d exp=0", d_fc); end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_small_frames();
    test_async_reset();
    test_frame_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
